// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch buffer
// Optional build macro: FETCH_MISALIGN_CHECK_EN adds a per-entry misalign flag.
package fetch_pkg;

  localparam int FETCH_ADDRESS_WIDTH = 32;
  localparam int FETCH_DATA_WIDTH    = 32;

  // RISC-V canonical NOP (addi x0, x0, 0) substituted for misaligned fetches
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_ADDRESS_WIDTH-1:0] pc;
    logic [FETCH_DATA_WIDTH-1:0]    instr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                           misalign;
`endif
  } fetch_entry_t;

  // Width of an occupancy counter able to hold 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry synchronous FIFO of fetch entries with clear
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          push,
  input  fetch_entry_t                  push_data,
  input  logic                          pop,
  output fetch_entry_t                  head,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; clear behaves like reset for the bookkeeping state
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !(rst || clear)) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// rtl/instr_fetch_buffer.sv - PC accept, 1-cycle imem read and fetch FIFO toward decode
// Optional build macro: FETCH_MISALIGN_CHECK_EN (adds instr_misalign_o, NOPs misaligned PCs).
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = FETCH_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = FETCH_DATA_WIDTH,
  parameter int DEPTH         = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDRESS_WIDTH-1:0]     pc_i,
  input  logic                         pc_valid_i,
  output logic                         pc_ready_o,
  output logic                         imem_en_o,
  output logic [ADDRESS_WIDTH-1:0]     imem_addr_o,
  input  logic [DATA_WIDTH-1:0]        imem_rdata_i,
  output logic [DATA_WIDTH-1:0]        instr_o,
  output logic [ADDRESS_WIDTH-1:0]     instr_pc_o,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  input  logic                         flush_i,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic                         instr_misalign_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  logic                     accept;
  logic                     inflight_v;
  logic [ADDRESS_WIDTH-1:0] inflight_pc;
  logic                     push;
  logic                     pop;
  fetch_entry_t             push_data;
  fetch_entry_t             head;

  // Credit counts the in-flight read so its response always has a slot;
  // only registered state is used, keeping instr_ready_i off this path
  assign pc_ready_o  = !rst && !flush_i &&
                       ((int'(count_o) + int'(inflight_v)) < DEPTH);
  assign accept      = pc_valid_i & pc_ready_o;
  assign imem_en_o   = accept;
  assign imem_addr_o = pc_i;

  // Response of the previous cycle's read is captured unless a redirect kills it
  assign push = inflight_v & ~flush_i;
  assign pop  = instr_valid_o & instr_ready_i;

  // Build the entry from the in-flight PC and the memory's returning data
  always_comb begin
    push_data       = '0;
    push_data.pc    = inflight_pc;
    push_data.instr = imem_rdata_i;
`ifdef FETCH_MISALIGN_CHECK_EN
    push_data.misalign = |inflight_pc[1:0];
`endif
  end

  // Track the single outstanding read; reset and flush both cancel it
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight_v <= accept;
      if (accept) inflight_pc <= pc_i;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count_o)
  );

  assign instr_valid_o = (count_o != '0);
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;

  // Head instruction is zeroed when empty; misaligned entries become NOPs
  always_comb begin
    instr_o = '0;
    if (instr_valid_o) begin
      instr_o = head.instr;
`ifdef FETCH_MISALIGN_CHECK_EN
      if (head.misalign) instr_o = NOP_INSTR;
`endif
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  assign instr_misalign_o = instr_valid_o & head.misalign;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb/tb_instr_fetch_buffer.sv - vectors, corner sequences and random run against a queue model
module tb_instr_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic        flush_i;
  logic [2:0]  count_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        instr_misalign_o;
`endif

  instr_fetch_buffer #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .DEPTH         (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .pc_ready_o    (pc_ready_o),
    .imem_en_o     (imem_en_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .flush_i       (flush_i),
`ifdef FETCH_MISALIGN_CHECK_EN
    .instr_misalign_o (instr_misalign_o),
`endif
    .count_o       (count_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: 1-cycle latency, data = 0x1000 + address, garbage when idle
  always @(posedge clk) begin
    imem_rdata_i <= imem_en_o ? (32'h1000 + imem_addr_o) : 32'hdeadbeef;
  end

  typedef struct {
    bit          pcv;
    logic [31:0] pc;
    bit          rdy;
    bit          fl;
    bit          e_prdy;
    bit          e_val;
    logic [31:0] e_pc;
    int          e_cnt;
    logic [31:0] e_instr;
    bit          e_mis;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference: PCs visible to decode in order, plus the one read still in memory
  logic [31:0] model_q [$];
  bit          pend_v = 1'b0;
  logic [31:0] pend_pc = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic bit misaligned(input logic [31:0] pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    return pc[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] fetched(input logic [31:0] pc);
    return misaligned(pc) ? 32'h00000013 : 32'h1000 + pc;
  endfunction

  function automatic vec_t mk(input bit pcv, input logic [31:0] pc, input bit rdy, input bit fl,
                              input bit prdy, input bit val, input logic [31:0] epc, input int cnt);
    vec_t v;
    v.pcv = pcv; v.pc = pc; v.rdy = rdy; v.fl = fl;
    v.e_prdy = prdy; v.e_val = val; v.e_pc = epc; v.e_cnt = cnt;
    v.e_instr = val ? 32'h1000 + epc : 32'h0;
    v.e_mis = 1'b0;
    return v;
  endfunction

  // One clock: compare at negedge against model (and vector if given), then advance model
  task automatic cycle(input bit has_exp, input vec_t v, input string tag);
    bit e_rdy, e_val, acc, pop;
    @(negedge clk);
    e_rdy = !rst && !flush_i && ((model_q.size() + int'(pend_v)) < 4);
    e_val = model_q.size() > 0;
    chk({tag, " pc_ready"}, 32'(pc_ready_o), 32'(e_rdy));
    chk({tag, " valid"}, 32'(instr_valid_o), 32'(e_val));
    chk({tag, " count"}, 32'(count_o), 32'(model_q.size()));
    chk({tag, " instr_pc"}, instr_pc_o, e_val ? model_q[0] : 32'h0);
    chk({tag, " instr"}, instr_o, e_val ? fetched(model_q[0]) : 32'h0);
    chk({tag, " imem_en"}, 32'(imem_en_o), 32'(pc_valid_i && e_rdy));
    if (imem_en_o) chk({tag, " imem_addr"}, imem_addr_o, pc_i);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk({tag, " misalign"}, 32'(instr_misalign_o), 32'(e_val && misaligned(model_q[0])));
`endif
    if (has_exp) begin
      chk({tag, " vec_pc_ready"}, 32'(pc_ready_o), 32'(v.e_prdy));
      chk({tag, " vec_valid"}, 32'(instr_valid_o), 32'(v.e_val));
      chk({tag, " vec_count"}, 32'(count_o), 32'(v.e_cnt));
      chk({tag, " vec_instr_pc"}, instr_pc_o, v.e_pc);
      chk({tag, " vec_instr"}, instr_o, v.e_instr);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk({tag, " vec_misalign"}, 32'(instr_misalign_o), 32'(v.e_mis));
`endif
    end
    acc = pc_valid_i && e_rdy;
    pop = e_val && instr_ready_i;
    @(posedge clk);
    if (rst || flush_i) begin
      model_q.delete();
      pend_v = 1'b0;
    end else begin
      if (pop) void'(model_q.pop_front());
      if (pend_v) model_q.push_back(pend_pc);
      pend_v  = acc;
      pend_pc = pc_i;
    end
    #1;
  endtask

  task automatic apply(input vec_t v, input string tag);
    pc_valid_i    = v.pcv;
    pc_i          = v.pc;
    instr_ready_i = v.rdy;
    flush_i       = v.fl;
    cycle(1'b1, v, tag);
  endtask

  task automatic idle(input int n, input bit rdy);
    vec_t nv;
    nv = mk(0, 0, rdy, 0, 0, 0, 0, 0);
    pc_valid_i = 1'b0; pc_i = '0; instr_ready_i = rdy; flush_i = 1'b0;
    for (int k = 0; k < n; k++) cycle(1'b0, nv, "idle");
  endtask

  vec_t tbl [14];

  initial begin
    rst = 1'b1; pc_valid_i = 1'b0; pc_i = '0; instr_ready_i = 1'b1; flush_i = 1'b0;
    idle(2, 1'b1);
    rst = 1'b0;

    // Streaming from reset, then decode stall filling the FIFO, release, full with pop+push
    tbl[0]  = mk(1, 0,  1, 0, 1, 0, 0,  0);
    tbl[1]  = mk(1, 4,  1, 0, 1, 0, 0,  0);
    tbl[2]  = mk(1, 8,  1, 0, 1, 1, 0,  1);
    tbl[3]  = mk(1, 12, 1, 0, 1, 1, 4,  1);
    tbl[4]  = mk(1, 16, 0, 0, 1, 1, 8,  1);
    tbl[5]  = mk(1, 20, 0, 0, 1, 1, 8,  2);
    tbl[6]  = mk(1, 24, 0, 0, 0, 1, 8,  3);
    tbl[7]  = mk(1, 24, 0, 0, 0, 1, 8,  4);
    tbl[8]  = mk(1, 24, 1, 0, 0, 1, 8,  4);
    tbl[9]  = mk(1, 24, 1, 0, 1, 1, 12, 3);
    tbl[10] = mk(1, 28, 1, 0, 1, 1, 16, 2);
    tbl[11] = mk(1, 32, 0, 0, 1, 1, 20, 2);
    tbl[12] = mk(1, 36, 1, 0, 0, 1, 20, 3);
    tbl[13] = mk(1, 36, 1, 0, 1, 1, 24, 3);
    for (int i = 0; i < 14; i++) apply(tbl[i], $sformatf("vec%0d", i));
    idle(6, 1'b1);

    // Flush with three buffered entries and pc 0x20 in flight, then refetch at 0x80
    apply(mk(1, 'h14, 0, 0, 1, 0, 0, 0), "fl0");
    apply(mk(1, 'h18, 0, 0, 1, 0, 0, 0), "fl1");
    apply(mk(1, 'h1c, 0, 0, 1, 1, 'h14, 1), "fl2");
    apply(mk(1, 'h20, 0, 0, 1, 1, 'h14, 2), "fl3");
    apply(mk(1, 'h80, 0, 1, 0, 1, 'h14, 3), "fl4");
    apply(mk(1, 'h80, 1, 0, 1, 0, 0, 0), "fl5");
    apply(mk(0, 0,    1, 0, 1, 0, 0, 0), "fl6");
    apply(mk(0, 0,    1, 0, 1, 1, 'h80, 1), "fl7");
    idle(2, 1'b1);

    // Flush while empty only drops pc_ready for that cycle
    apply(mk(1, 'h90, 1, 1, 0, 0, 0, 0), "fle0");
    apply(mk(0, 0,    1, 0, 1, 0, 0, 0), "fle1");

    // Reset mid-stream with two entries buffered
    apply(mk(1, 'h40, 0, 0, 1, 0, 0, 0), "rs0");
    apply(mk(1, 'h44, 0, 0, 1, 0, 0, 0), "rs1");
    apply(mk(0, 0,    0, 0, 1, 1, 'h40, 1), "rs2");
    rst = 1'b1;
    apply(mk(0, 0,    0, 0, 0, 1, 'h40, 2), "rs3");
    rst = 1'b0;
    apply(mk(0, 0,    1, 0, 1, 0, 0, 0), "rs4");

`ifdef FETCH_MISALIGN_CHECK_EN
    begin
      vec_t mv;
      apply(mk(1, 'h6, 0, 0, 1, 0, 0, 0), "mis0");
      apply(mk(1, 'h8, 0, 0, 1, 0, 0, 0), "mis1");
      mv = mk(0, 0, 1, 0, 1, 1, 'h6, 1);
      mv.e_instr = 32'h00000013;
      mv.e_mis   = 1'b1;
      apply(mv, "mis2");
      apply(mk(0, 0, 1, 0, 1, 1, 'h8, 1), "mis3");
      idle(2, 1'b1);
    end
`endif

    // Random traffic against the queue model, with sporadic flush and reset
    for (int i = 0; i < 600; i++) begin
      vec_t nv;
      nv = mk(0, 0, 0, 0, 0, 0, 0, 0);
      rst           = ($urandom_range(0, 99) == 0);
      pc_valid_i    = ($urandom_range(0, 3) != 0);
`ifdef FETCH_MISALIGN_CHECK_EN
      pc_i          = 32'($urandom_range(0, 1023));
`else
      pc_i          = 32'($urandom_range(0, 255)) << 2;
`endif
      instr_ready_i = ($urandom_range(0, 2) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      cycle(1'b0, nv, "rand");
    end
    rst = 1'b0;
    idle(6, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
